// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, ACK/NACK, STOP.
// Define I2C_CLK_STRETCH_EN for open-drain SCL with subordinate clock stretching.
module i2c_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_400,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
`ifdef I2C_CLK_STRETCH_EN
  inout  wire        SCL,
`else
  output logic       SCL,
`endif
  inout  wire        SDA
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_NACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [7:0]    wdata_q;
  logic          rw_q;

  logic scl_q, sda_o_q, sda_oe_q;
  logic scl_nxt, sda_o_nxt, sda_oe_nxt;
  logic sda_in, q_hold, tick, sample, bit_end, accept, bit_scl;

  assign sda_in  = SDA;
  assign accept  = (state == S_IDLE) && start;
  assign tick    = (qcnt == Q_LAST) && !q_hold;
  assign sample  = tick && (phase == 2'd1);
  assign bit_end = tick && (phase == 2'd3);
  assign bit_scl = (phase == 2'd1) || (phase == 2'd2);

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  assign SDA = sda_oe_q ? sda_o_q : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) scl_sync <= 2'b11;
    else     scl_sync <= {scl_sync[0], SCL};
  end

  // A subordinate holding SCL low freezes the high phase until the line is seen high.
  assign q_hold = (phase == 2'd1) && !scl_sync[1] &&
                  (state != S_IDLE) && (state != S_DONE);
  assign SCL    = scl_q ? 1'bz : 1'b0;
`else
  assign q_hold = 1'b0;
  assign SCL    = scl_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      qcnt  <= '0;
      phase <= 2'd0;
    end else if (state == S_IDLE || state == S_DONE) begin
      qcnt  <= '0;
      phase <= 2'd0;
    end else if (!q_hold) begin
      if (qcnt == Q_LAST) begin
        qcnt  <= '0;
        phase <= phase + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start) state_nxt = S_START;
      S_START:     if (bit_end) state_nxt = S_ADDR;
      S_ADDR:      if (bit_end && bit_cnt == 3'd0) state_nxt = S_ADDR_ACK;
      S_ADDR_ACK:
        if (bit_end) begin
          if (ack_error)  state_nxt = S_STOP;
          else if (rw_q)  state_nxt = S_READ;
          else            state_nxt = S_WRITE;
        end
      S_WRITE:     if (bit_end && bit_cnt == 3'd0) state_nxt = S_WRITE_ACK;
      S_WRITE_ACK: if (bit_end) state_nxt = S_STOP;
      S_READ:      if (bit_end && bit_cnt == 3'd0) state_nxt = S_READ_NACK;
      S_READ_NACK: if (bit_end) state_nxt = S_STOP;
      S_STOP:      if (bit_end) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Bus drive decode; registered below so SCL/SDA never glitch on counter transitions.
  always_comb begin
    scl_nxt    = 1'b1;
    sda_oe_nxt = 1'b0;
    sda_o_nxt  = 1'b1;
    unique case (state)
      S_START: begin
        sda_oe_nxt = 1'b1;
        sda_o_nxt  = !phase[1];
      end
      S_ADDR, S_WRITE: begin
        scl_nxt    = bit_scl;
        sda_oe_nxt = 1'b1;
        sda_o_nxt  = shift_reg[7];
      end
      S_ADDR_ACK, S_WRITE_ACK, S_READ: begin
        scl_nxt = bit_scl;
      end
      S_READ_NACK: begin
        scl_nxt    = bit_scl;
        sda_oe_nxt = 1'b1;
      end
      S_STOP: begin
        scl_nxt    = (phase != 2'd0);
        sda_oe_nxt = 1'b1;
        sda_o_nxt  = (phase == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      sda_o_q  <= 1'b1;
    end else begin
      scl_q    <= scl_nxt;
      sda_oe_q <= sda_oe_nxt;
      sda_o_q  <= sda_o_nxt;
    end
  end

  always_ff @(posedge clk_400 or posedge rst) begin
    if (rst) begin
      shift_reg <= 8'h00;
      wdata_q   <= 8'h00;
      rw_q      <= 1'b0;
      bit_cnt   <= 3'd0;
      rdata     <= 8'h00;
      ack_error <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:
          if (accept) begin
            shift_reg <= {addr, rw};
            wdata_q   <= wdata;
            rw_q      <= rw;
            ack_error <= 1'b0;
          end
        S_START:
          if (bit_end) bit_cnt <= 3'd7;
        S_ADDR, S_WRITE:
          if (bit_end) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            if (bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
          end
        S_ADDR_ACK: begin
          if (sample && sda_in) ack_error <= 1'b1;
          if (bit_end) begin
            bit_cnt   <= 3'd7;
            shift_reg <= wdata_q;
          end
        end
        S_WRITE_ACK:
          if (sample && sda_in) ack_error <= 1'b1;
        S_READ: begin
          if (sample) rdata <= {rdata[6:0], sda_in};
          if (bit_end && bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Self-checking bench for i2c_master_byte with a behavioural I2C subordinate at address 7'h01.
module tb_i2c_master_byte;

  localparam logic [6:0] SLV_ADDR = 7'h01;
  localparam int         BUDGET   = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, ack_error, scl;
  wire        sda;

  int n_checks = 0;
  int n_err    = 0;

  i2c_master_byte #(.CLK_DIV(4)) dut (
    .clk_400  (clk),
    .rst      (rst),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .ack_error(ack_error),
    .SCL      (scl),
    .SDA      (sda)
  );

  always #5 clk = ~clk;

  // Behavioural subordinate: samples the bus on the falling clk edge.
  logic       s_low = 1'b0;
  logic       s_next_low = 1'b0;
  logic [7:0] slv_rd = 8'h00;
  logic       slv_ack_data = 1'b1;
  logic       scl_d = 1'b1, sda_d = 1'b1;
  logic       s_active = 1'b0, s_acked = 1'b0, s_read = 1'b0, s_ninth = 1'b0;
  logic [7:0] s_rx = 8'h00, s_addr_byte = 8'h00, s_data_byte = 8'h00;
  int         s_cnt = 0, s_byte = 0, scl_low_cnt = 0;
  int         starts = 0, stops = 0, rises = 0, done_cnt = 0;

  pullup (sda);
  assign sda = s_low ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    scl_d       <= scl;
    sda_d       <= sda;
    scl_low_cnt <= scl ? 0 : scl_low_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!scl_d && scl) rises <= rises + 1;
    if (scl_d && scl && sda_d && !sda) begin
      s_active <= 1'b1;
      s_cnt    <= 0;
      s_byte   <= 0;
      s_low    <= 1'b0;
      s_acked  <= 1'b0;
      s_read   <= 1'b0;
      s_ninth  <= 1'b0;
      starts   <= starts + 1;
    end else if (scl_d && scl && !sda_d && sda) begin
      s_active <= 1'b0;
      s_low    <= 1'b0;
      stops    <= stops + 1;
    end else if (s_active) begin
      if (!scl_d && scl) begin
        if (s_cnt < 8) s_rx <= {s_rx[6:0], sda};
        else           s_ninth <= sda;
        s_cnt <= s_cnt + 1;
      end else if (scl_d && !scl) begin
        s_low      <= 1'b0;
        s_next_low <= 1'b0;
        if (s_cnt == 8) begin
          if (s_byte == 0) begin
            s_addr_byte <= s_rx;
            if (s_rx[7:1] == SLV_ADDR) begin
              s_next_low <= 1'b1;
              s_acked    <= 1'b1;
              s_read     <= s_rx[0];
            end
          end else if (!s_read) begin
            s_data_byte <= s_rx;
            s_next_low  <= slv_ack_data;
          end
        end else if (s_cnt == 9) begin
          s_cnt  <= 0;
          s_byte <= s_byte + 1;
          if (s_byte == 0 && s_acked && s_read) s_next_low <= !slv_rd[7];
        end else if (s_cnt >= 1 && s_byte == 1 && s_read) begin
          s_next_low <= !slv_rd[7 - s_cnt];
        end
      end else if (!scl && scl_low_cnt == 5) begin
        s_low <= s_next_low;
      end
    end
  end

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] slv_rd;
    logic       slv_ack;
    logic       exp_err;
    logic [7:0] exp_rdata;
    logic [7:0] exp_addr_byte;
    logic       chk_wr;
    logic [7:0] exp_wr;
    int         exp_rises;
  } vec_t;

  vec_t vecs[7];
  int   base_done, base_starts, base_stops, base_rises;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic snapshot();
    base_done   = done_cnt;
    base_starts = starts;
    base_stops  = stops;
    base_rises  = rises;
  endtask

  task automatic launch(input string tag, input logic r, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    rw    = r;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_accept"}, busy, 1'b1);
    rw    = ~r;
    addr  = ~a;
    wdata = ~d;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, seen, 1'b1);
  endtask

  initial begin
    //            rw    addr   wdata  slv_rd ack   err   rdata  addrB  chk   wr     rises
    vecs[0] = '{1'b0, 7'h01, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 8'hA5, 19};
    vecs[1] = '{1'b1, 7'h01, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C, 8'h03, 1'b0, 8'h00, 19};
    vecs[2] = '{1'b0, 7'h05, 8'hA5, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h0A, 1'b0, 8'h00, 10};
    vecs[3] = '{1'b0, 7'h01, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h02, 1'b1, 8'h5A, 19};
    vecs[4] = '{1'b1, 7'h01, 8'h00, 8'h81, 1'b1, 1'b0, 8'h81, 8'h03, 1'b0, 8'h00, 19};
    vecs[5] = '{1'b1, 7'h05, 8'h00, 8'h55, 1'b1, 1'b1, 8'h81, 8'h0B, 1'b0, 8'h00, 10};
    vecs[6] = '{1'b0, 7'h01, 8'h00, 8'h00, 1'b1, 1'b0, 8'h81, 8'h02, 1'b1, 8'h00, 19};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset ack_error", ack_error, 1'b0);
    check("reset rdata", rdata, 8'h00);
    check("reset scl", scl, 1'b1);
    check("reset sda", sda, 1'b1);

    for (int i = 0; i < 7; i++) begin
      string tag = $sformatf("v%0d", i);
      slv_rd       = vecs[i].slv_rd;
      slv_ack_data = vecs[i].slv_ack;
      snapshot();
      launch(tag, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      wait_done(tag);
      check({tag, " busy_at_done"}, busy, 1'b0);
      check({tag, " ack_error"}, ack_error, vecs[i].exp_err);
      check({tag, " rdata"}, rdata, vecs[i].exp_rdata);
      check({tag, " addr_byte"}, s_addr_byte, vecs[i].exp_addr_byte);
      if (vecs[i].chk_wr) check({tag, " write_byte"}, s_data_byte, vecs[i].exp_wr);
      if (vecs[i].rw && !vecs[i].exp_err) check({tag, " master_nack"}, s_ninth, 1'b1);
      repeat (3) @(negedge clk);
      check({tag, " scl_rises"}, rises - base_rises, vecs[i].exp_rises);
      check({tag, " done_pulses"}, done_cnt - base_done, 1);
      check({tag, " starts"}, starts - base_starts, 1);
      check({tag, " stops"}, stops - base_stops, 1);
      check({tag, " scl_idle"}, scl, 1'b1);
    end

    // start pulsed mid-WRITE with a different target must be ignored
    slv_ack_data = 1'b1;
    snapshot();
    launch("busy_start", 1'b0, 7'h01, 8'hA5);
    repeat (220) @(negedge clk);
    start = 1'b1;
    rw    = 1'b1;
    addr  = 7'h7F;
    wdata = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start ack_error", ack_error, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_start addr_byte", s_addr_byte, 8'h02);
    check("busy_start write_byte", s_data_byte, 8'hA5);
    check("busy_start done_pulses", done_cnt - base_done, 1);
    check("busy_start starts", starts - base_starts, 1);

    // start during DONE is ignored; start held into the next cycle is accepted
    snapshot();
    launch("done_start", 1'b0, 7'h01, 8'h3C);
    wait_done("done_start");
    start = 1'b1;
    rw    = 1'b0;
    addr  = 7'h01;
    wdata = 8'hC3;
    @(negedge clk);
    check("start_in_done ignored", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("start_after_done accepted", busy, 1'b1);
    wait_done("done_start second");
    repeat (3) @(negedge clk);
    check("done_start write_byte", s_data_byte, 8'hC3);
    check("done_start done_pulses", done_cnt - base_done, 2);

    // asynchronous reset during address bit 4, then a clean transaction
    snapshot();
    launch("mid_reset", 1'b0, 7'h01, 8'hA5);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < BUDGET && !hit; i++) begin
        @(negedge clk);
        if (rises - base_rises == 4) hit = 1'b1;
      end
      check("mid_reset reached_bit4", hit, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset scl", scl, 1'b1);
    check("mid_reset sda", sda, 1'b1);
    check("mid_reset busy", busy, 1'b0);
    check("mid_reset rdata", rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    snapshot();
    launch("after_reset", 1'b0, 7'h01, 8'h96);
    wait_done("after_reset");
    check("after_reset ack_error", ack_error, 1'b0);
    repeat (3) @(negedge clk);
    check("after_reset starts", starts - base_starts, 1);
    check("after_reset addr_byte", s_addr_byte, 8'h02);
    check("after_reset write_byte", s_data_byte, 8'h96);
    check("after_reset stops", stops - base_stops, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
